// File: rtl/wt_mem_req_arbiter.sv
// Shares one memory request channel between the write-through I$ and D$.
// Round-robin grant locked until ack; per-source credits; returns routed by ID MSB.
//   state  | meaning
//   IDLE   | no grant held; an eligible source is requested combinationally
//   LOCKED | request issued but not acked; sel_q held until mem_ack_i
module wt_mem_req_arbiter #(
  parameter int unsigned ReqWidth       = 128,
  parameter int unsigned TidWidth       = 3,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                icache_req_i,
  input  logic [ReqWidth-1:0] icache_data_i,
  input  logic [TidWidth-1:0] icache_tid_i,
  output logic                icache_ack_o,
  output logic                icache_rtrn_vld_o,
  input  logic                dcache_req_i,
  input  logic [ReqWidth-1:0] dcache_data_i,
  input  logic [TidWidth-1:0] dcache_tid_i,
  output logic                dcache_ack_o,
  output logic                dcache_rtrn_vld_o,
  output logic                mem_req_o,
  output logic [ReqWidth-1:0] mem_data_o,
  output logic [TidWidth:0]   mem_id_o,
  input  logic                mem_ack_i,
  input  logic                mem_rtrn_vld_i,
  input  logic [TidWidth:0]   mem_rtrn_id_i,
  input  logic                quiesce_i,
  output logic                idle_o,
  output logic                err_o
);

  localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);
  localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxOutstanding);

  typedef enum logic {ST_IDLE, ST_LOCKED} state_e;

  state_e              state_q, state_d;
  logic                sel_q, sel_d;
  logic                rr_ptr_q, rr_ptr_d;
  logic [CntWidth-1:0] icnt_q, icnt_d;
  logic [CntWidth-1:0] dcnt_q, dcnt_d;
  logic                err_q, err_d;

  logic i_elig, d_elig, grant_vld, grant_src, sel_c, ack_c;
  logic icnt_err, dcnt_err;
  logic unused_rtrn_tid;

  assign unused_rtrn_tid = ^mem_rtrn_id_i[TidWidth-1:0];

  always_comb begin
    i_elig    = icache_req_i & (icnt_q < CntMax) & ~quiesce_i;
    d_elig    = dcache_req_i & (dcnt_q < CntMax) & ~quiesce_i;
    grant_vld = i_elig | d_elig;
    grant_src = (i_elig & d_elig) ? rr_ptr_q : d_elig;
  end

  // FSM: state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_vld && !mem_ack_i) begin
          state_d = ST_LOCKED;
          sel_d   = grant_src;
        end
      end
      ST_LOCKED: begin
        if (mem_ack_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    mem_req_o = 1'b0;
    sel_c     = sel_q;
    case (state_q)
      ST_IDLE: begin
        mem_req_o = grant_vld;
        sel_c     = grant_src;
      end
      ST_LOCKED: begin
        mem_req_o = 1'b1;
        sel_c     = sel_q;
      end
      default: begin
        mem_req_o = 1'b0;
        sel_c     = sel_q;
      end
    endcase
  end

  assign mem_data_o        = sel_c ? dcache_data_i : icache_data_i;
  assign mem_id_o          = {sel_c, (sel_c ? dcache_tid_i : icache_tid_i)};
  assign ack_c             = mem_req_o & mem_ack_i;
  assign icache_ack_o      = ack_c & ~sel_c;
  assign dcache_ack_o      = ack_c & sel_c;
  assign icache_rtrn_vld_o = mem_rtrn_vld_i & ~mem_rtrn_id_i[TidWidth];
  assign dcache_rtrn_vld_o = mem_rtrn_vld_i & mem_rtrn_id_i[TidWidth];

  // Returns {error, next count}; simultaneous issue and return cancel out.
  function automatic logic [CntWidth:0] upd_cnt(input logic [CntWidth-1:0] cnt,
                                                  input logic inc, input logic dec);
    logic [CntWidth-1:0] nxt;
    logic                err;
    nxt = cnt;
    err = 1'b0;
    if (inc && !dec) begin
      if (cnt == CntMax) err = 1'b1;
      else               nxt = cnt + CntWidth'(1);
    end else if (dec && !inc) begin
      if (cnt == '0) err = 1'b1;
      else           nxt = cnt - CntWidth'(1);
    end
    return {err, nxt};
  endfunction

  always_comb begin
    {icnt_err, icnt_d} = upd_cnt(icnt_q, icache_ack_o, icache_rtrn_vld_o);
    {dcnt_err, dcnt_d} = upd_cnt(dcnt_q, dcache_ack_o, dcache_rtrn_vld_o);
    err_d              = err_q | icnt_err | dcnt_err;
    rr_ptr_d           = ack_c ? ~sel_c : rr_ptr_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sel_q    <= 1'b0;
      rr_ptr_q <= 1'b0;
      icnt_q   <= '0;
      dcnt_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      sel_q    <= sel_d;
      rr_ptr_q <= rr_ptr_d;
      icnt_q   <= icnt_d;
      dcnt_q   <= dcnt_d;
      err_q    <= err_d;
    end
  end

  assign err_o  = err_q;
  assign idle_o = (state_q == ST_IDLE) & ~mem_req_o & (icnt_q == '0) & (dcnt_q == '0);

`ifndef SYNTHESIS
  // A locked requester must keep its request up until the channel acks it.
  a_req_held : assert property (@(posedge clk_i) disable iff (rst_i)
    (state_q == ST_LOCKED) |-> (sel_q ? dcache_req_i : icache_req_i));
`endif

endmodule

// File: tb/tb_wt_mem_req_arbiter.sv
// Directed bench for wt_mem_req_arbiter: arbitration, locking, credits, quiesce, errors.
module tb_wt_mem_req_arbiter;

  localparam logic [127:0] IDATA = {4{32'h1111_AAAA}};
  localparam logic [127:0] DDATA = {4{32'h2222_DDDD}};

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         icache_req_i, dcache_req_i;
  logic [127:0] icache_data_i, dcache_data_i;
  logic [2:0]   icache_tid_i, dcache_tid_i;
  logic         icache_ack_o, dcache_ack_o;
  logic         icache_rtrn_vld_o, dcache_rtrn_vld_o;
  logic         mem_req_o;
  logic [127:0] mem_data_o;
  logic [3:0]   mem_id_o;
  logic         mem_ack_i, mem_rtrn_vld_i;
  logic [3:0]   mem_rtrn_id_i;
  logic         quiesce_i, idle_o, err_o;

  int n_checks = 0;
  int n_errors = 0;

  wt_mem_req_arbiter #(.ReqWidth(128), .TidWidth(3), .MaxOutstanding(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .icache_req_i(icache_req_i), .icache_data_i(icache_data_i), .icache_tid_i(icache_tid_i),
    .icache_ack_o(icache_ack_o), .icache_rtrn_vld_o(icache_rtrn_vld_o),
    .dcache_req_i(dcache_req_i), .dcache_data_i(dcache_data_i), .dcache_tid_i(dcache_tid_i),
    .dcache_ack_o(dcache_ack_o), .dcache_rtrn_vld_o(dcache_rtrn_vld_o),
    .mem_req_o(mem_req_o), .mem_data_o(mem_data_o), .mem_id_o(mem_id_o),
    .mem_ack_i(mem_ack_i), .mem_rtrn_vld_i(mem_rtrn_vld_i), .mem_rtrn_id_i(mem_rtrn_id_i),
    .quiesce_i(quiesce_i), .idle_o(idle_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_in();
    icache_req_i   = 1'b0;
    dcache_req_i   = 1'b0;
    mem_ack_i      = 1'b0;
    mem_rtrn_vld_i = 1'b0;
    mem_rtrn_id_i  = 4'h0;
  endtask

  // One return per cycle for each id in turn; routing checked against the id MSB.
  task automatic drain(input logic [3:0] id);
    mem_rtrn_vld_i = 1'b1;
    mem_rtrn_id_i  = id;
    #1;
    check("rtrn_i_route", icache_rtrn_vld_o, {31'd0, ~id[3]});
    check("rtrn_d_route", dcache_rtrn_vld_o, {31'd0, id[3]});
    tick();
    mem_rtrn_vld_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1;
    quiesce_i = 1'b0;
    icache_data_i = IDATA;
    dcache_data_i = DDATA;
    icache_tid_i = 3'd2;
    dcache_tid_i = 3'd6;
    clear_in();
    repeat (2) tick();
    rst_i = 1'b0;
    #1;
    check("rst_idle", idle_o, 1);
    check("rst_req", mem_req_o, 0);
    check("rst_err", err_o, 0);
    check("rst_acks", {icache_ack_o, dcache_ack_o}, 0);

    // Both held, always acked: strict alternation starting with I$.
    for (int i = 0; i < 4; i++) begin
      icache_req_i = 1'b1;
      dcache_req_i = 1'b1;
      mem_ack_i    = 1'b1;
      #1;
      check("alt_req", mem_req_o, 1);
      check("alt_id", mem_id_o, (i % 2 == 0) ? 32'h2 : 32'hE);
      check("alt_data", mem_data_o[31:0], (i % 2 == 0) ? 32'h1111_AAAA : 32'h2222_DDDD);
      check("alt_iack", icache_ack_o, (i % 2 == 0) ? 1 : 0);
      check("alt_dack", dcache_ack_o, (i % 2 == 0) ? 0 : 1);
      tick();
    end
    clear_in();
    #1;
    check("alt_busy_idle", idle_o, 0);
    drain(4'h0); drain(4'h8); drain(4'h1); drain(4'h9);
    #1;
    check("alt_drained_idle", idle_o, 1);

    // D$ locked for 3 unacked cycles while I$ competes.
    dcache_req_i = 1'b1;
    #1;
    check("lock_c1_req", mem_req_o, 1);
    check("lock_c1_src", mem_id_o[3], 1);
    check("lock_c1_dack", dcache_ack_o, 0);
    tick();
    icache_req_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("lock_hold_req", mem_req_o, 1);
      check("lock_hold_src", mem_id_o[3], 1);
      check("lock_hold_acks", {icache_ack_o, dcache_ack_o}, 0);
      tick();
    end
    mem_ack_i = 1'b1;
    #1;
    check("lock_c4_dack", dcache_ack_o, 1);
    check("lock_c4_iack", icache_ack_o, 0);
    tick();
    dcache_req_i = 1'b0;
    #1;
    check("lock_c5_iack", icache_ack_o, 1);
    check("lock_c5_src", mem_id_o[3], 0);
    tick();
    clear_in();
    drain(4'h3); drain(4'hA);
    #1;
    check("lock_drained_idle", idle_o, 1);

    // I$ exhausts its 4 credits; D$ still served; one return reopens I$.
    icache_req_i = 1'b1;
    mem_ack_i    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("cred_iack", icache_ack_o, 1);
      tick();
    end
    #1;
    check("cred_block_req", mem_req_o, 0);
    check("cred_block_iack", icache_ack_o, 0);
    tick();
    dcache_req_i = 1'b1;
    #1;
    check("cred_d_ack", dcache_ack_o, 1);
    check("cred_d_src", mem_id_o[3], 1);
    tick();
    dcache_req_i   = 1'b0;
    mem_rtrn_vld_i = 1'b1;
    mem_rtrn_id_i  = 4'h4;
    #1;
    check("cred_still_block", mem_req_o, 0);
    check("cred_rtrn_i", icache_rtrn_vld_o, 1);
    tick();
    mem_rtrn_vld_i = 1'b0;
    #1;
    check("cred_reopen_iack", icache_ack_o, 1);
    tick();
    clear_in();
    #1;
    check("cred_icnt", dut.icnt_q, 4);
    drain(4'h0); drain(4'h1); drain(4'h2); drain(4'h3); drain(4'hB);
    #1;
    check("cred_drained_idle", idle_o, 1);

    // D$ return and D$ ack in the same cycle leave the count unchanged.
    dcache_req_i = 1'b1;
    mem_ack_i    = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("same_pre_dack", dcache_ack_o, 1);
      tick();
    end
    mem_rtrn_vld_i = 1'b1;
    mem_rtrn_id_i  = 4'hD;
    #1;
    check("same_dack", dcache_ack_o, 1);
    check("same_drtrn", dcache_rtrn_vld_o, 1);
    check("same_irtrn", icache_rtrn_vld_o, 0);
    tick();
    clear_in();
    #1;
    check("same_dcnt", dut.dcnt_q, 2);
    check("same_err", err_o, 0);
    drain(4'h8); drain(4'h9);
    #1;
    check("same_drained_idle", idle_o, 1);

    // Quiesce while locked: the locked request completes, nothing else is granted.
    icache_req_i = 1'b1;
    #1;
    check("q_c1_req", mem_req_o, 1);
    check("q_c1_iack", icache_ack_o, 0);
    tick();
    quiesce_i = 1'b1;
    #1;
    check("q_locked_req", mem_req_o, 1);
    check("q_locked_src", mem_id_o[3], 0);
    tick();
    mem_ack_i = 1'b1;
    #1;
    check("q_locked_iack", icache_ack_o, 1);
    tick();
    dcache_req_i = 1'b1;
    #1;
    check("q_block_req", mem_req_o, 0);
    check("q_block_acks", {icache_ack_o, dcache_ack_o}, 0);
    check("q_busy_idle", idle_o, 0);
    tick();
    clear_in();
    drain(4'h2);
    #1;
    check("q_drained_idle", idle_o, 1);
    quiesce_i = 1'b0;

    // Return with no credit outstanding: sticky error, cleared only by reset.
    drain(4'h1);
    #1;
    check("err_set", err_o, 1);
    check("err_icnt", dut.icnt_q, 0);
    tick();
    tick();
    check("err_sticky", err_o, 1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    #1;
    check("err_rst_err", err_o, 0);
    check("err_rst_idle", idle_o, 1);
    check("err_rst_cnts", {dut.icnt_q, dut.dcnt_q}, 0);

    // Reset while locked, then a stale D$ return arrives.
    dcache_req_i = 1'b1;
    #1;
    check("mid_req", mem_req_o, 1);
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    dcache_req_i = 1'b0;
    #1;
    check("mid_rst_req", mem_req_o, 0);
    check("mid_rst_idle", idle_o, 1);
    drain(4'hC);
    #1;
    check("mid_stale_err", err_o, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wt_mem_req_arbiter.md
Name: wt_mem_req_arbiter

Overview:
- Shares one memory request channel (toward the AXI/L15 adapter) between the write-through I$ and D$ request ports.
- Round-robin arbitration with per-source outstanding-transaction credits.
- The grant stays locked to one source until the channel acknowledges.
- Routes returns back to the issuing cache by the transaction-ID MSB; provides quiesce/idle for flush sequencing.

Parameters:
- ReqWidth, 128, width of the opaque request payload (address, size, data, etc.).
- TidWidth, 3, per-source transaction ID width.
- MaxOutstanding, 4, maximum in-flight transactions per source (1..2**TidWidth).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- icache_req_i  in  1  I$ request valid; held until ack.
- icache_data_i  in  ReqWidth  I$ request payload.
- icache_tid_i  in  TidWidth  I$ transaction ID.
- icache_ack_o  out  1  I$ request accepted.
- icache_rtrn_vld_o  out  1  return for I$.
- dcache_req_i  in  1  D$ request valid; held until ack.
- dcache_data_i  in  ReqWidth  D$ request payload.
- dcache_tid_i  in  TidWidth  D$ transaction ID.
- dcache_ack_o  out  1  D$ request accepted.
- dcache_rtrn_vld_o  out  1  return for D$.
- mem_req_o  out  1  request to adapter.
- mem_data_o  out  ReqWidth  payload of granted source.
- mem_id_o  out  TidWidth+1  {src, tid}; src 0 = I$, 1 = D$.
- mem_ack_i  in  1  adapter accepts request.
- mem_rtrn_vld_i  in  1  return valid.
- mem_rtrn_id_i  in  TidWidth+1  return ID.
- quiesce_i  in  1  block new grants.
- idle_o  out  1  no request pending and no transaction outstanding.
- err_o  out  1  sticky credit underflow/overflow error.

Behaviour:
- Clock and reset: one clock, clk_i. rst_i is synchronous and active-high.
- Reset values: state=IDLE, rr_ptr=0 (I$ preferred), both credit counters=0, err_o=0, mem_req_o=0, acks=0, idle_o=1.
- Eligibility: a source is eligible when its req is high, its count < MaxOutstanding, and quiesce_i=0.
- IDLE state:
  - No eligible source: mem_req_o=0.
  - Otherwise, pick the eligible source; if both are eligible, pick the one equal to rr_ptr.
  - mem_req_o=1 in the same cycle (zero-cycle request latency). mem_data_o/mem_id_o are muxed combinationally from the selected source.
  - mem_ack_i the same cycle: complete, stay IDLE. Otherwise latch sel and go to LOCKED.
- LOCKED state:
  - mem_req_o=1; sel is held regardless of the other source's request, quiesce_i, or credits.
  - On mem_ack_i, go to IDLE.
- Acks: icache_ack_o = mem_req_o & mem_ack_i & (sel==0); dcache_ack_o likewise for sel==1. Acks are combinational, not registered.
- On every ack: rr_ptr <= ~granted_src, and the granted source's counter increments.
- Returns: icache_rtrn_vld_o = mem_rtrn_vld_i & ~mem_rtrn_id_i[TidWidth]; dcache_rtrn_vld_o = mem_rtrn_vld_i & mem_rtrn_id_i[TidWidth].
  - A return decrements the matching source's counter.
  - Return and ack on the same source in the same cycle: counter unchanged.
- Error: a return to a source whose counter is 0 sets err_o (sticky until reset) and leaves the counter at 0. Increment at MaxOutstanding is impossible by construction; if detected, set err_o and saturate.
- A requester dropping req before ack is a protocol violation (assertion only). The arbiter still holds sel and completes on mem_ack_i.
- quiesce_i:
  - Blocks only IDLE-state grants.
  - A LOCKED request completes.
  - Returns continue to be routed and counted.
- idle_o = (state==IDLE) & ~mem_req_o & both counters==0. Combinational.
- Reset mid-transaction: all state clears next edge. Outstanding returns arriving after reset are routed but flag err_o (counter 0).
- Counter width: $clog2(MaxOutstanding+1).

Test Plan:
- Both requests held from reset, mem_ack_i always 1: grants alternate I$, D$, I$, D$. mem_id_o MSB toggles each cycle.
- D$ request, mem_ack_i withheld 3 cycles while I$ asserts: mem_req_o high 4 cycles, sel=D$ throughout. dcache_ack_o only in cycle 4, then I$ granted next cycle.
- MaxOutstanding=4, I$ issues 4 acked requests, no returns: 5th I$ request blocked (mem_req_o=0), D$ still granted. One I$ return (id MSB 0) re-enables I$ next cycle.
- Return with id={1,3'd5} while D$ count=2 and a D$ ack occurs the same cycle: dcache_rtrn_vld_o=1, D$ count stays 2.
- quiesce_i raised during LOCKED: current request acks, then no further grants. idle_o asserts once all returns drain to counts 0.
- Return to I$ with count 0: err_o=1 and stays 1. Assert rst_i one cycle: err_o=0, counts 0, idle_o=1.
